ps2_fifo_ctrl: RTL and testbench
================================

PS2_FIFO_CTRL -- requirements
Module: ps2_fifo_ctrl

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 2000: I_CLK cycles of host clock-low inhibit, and of start-bit hold before clock release.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: RX FIFO entries; power of 2, range 2..64.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000: maximum I_CLK cycles between PS2 clock falls inside a frame.
REQ-004 SHALL have port I_CLK, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port I_RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port I_ADDR, input, 2 bits: register select.
REQ-007 SHALL have port I_WRITE, input, 1 bit: single-cycle write strobe.
REQ-008 SHALL have port I_READ, input, 1 bit: single-cycle read strobe; pops the FIFO when I_ADDR=1.
REQ-009 SHALL have port I_WRDATA, input, 8 bits: write data.
REQ-010 SHALL have port O_RDDATA, output, 8 bits: combinational read mux of I_ADDR.
REQ-011 SHALL have port O_IRQ, output, 1 bit: registered interrupt, = IRQEN & (FIFO non-empty | any error flag).
REQ-012 SHALL have port IO_PS2CLK, inout, 1 bit: open-drain; driven 0 only by a registered enable, else Z.
REQ-013 SHALL have port IO_PS2DATA, inout, 1 bit: open-drain; drives 0 when the current TX bit is 0, else Z.

Function
REQ-014 SHALL pass IO_PS2CLK and IO_PS2DATA through 2-FF synchronizers; clkfall = previous synced clock 1 & current 0; all frame logic SHALL use synced values only.
REQ-015 SHALL implement states IDLE, INHIBIT, START, TXBITS, TXACK, RXBITS, RXEND.
REQ-016 IDLE -> INHIBIT on write to addr 2; else IDLE -> RXBITS on clkfall with synced data=0 (start bit).
REQ-017 INHIBIT: clock driven low for INHIBIT_CYC cycles, then START; START: clock released, data held 0 for INHIBIT_CYC cycles, then TXBITS.
REQ-018 TXBITS: on each clkfall shift out the next of 8 data bits LSB first, then odd parity; on the clkfall after parity release data (stop bit) and go to TXACK.
REQ-019 TXACK: on next clkfall sample data; 0 -> IDLE; 1 -> IDLE and set TXERR.
REQ-020 RXBITS: on each clkfall shift in 8 data bits LSB first, then parity bit, then stop bit; after the stop-bit fall -> RXEND.
REQ-021 RXEND, one cycle: parity must be odd over data+parity, stop must be 1.
REQ-022 RXEND, parity bad: set PERR, drop byte. Stop bad: set FERR, drop byte.
REQ-023 RXEND, both good: push to FIFO if not full, else set OVR and drop byte; then -> IDLE.
REQ-024 Timeout counter SHALL clear on every clkfall and on state entry; in TXBITS/TXACK/RXBITS reaching TIMEOUT_CYC-1 -> IDLE and set FERR; no FIFO push.
REQ-025 Write to addr 2 outside IDLE SHALL be dropped and set TXERR; an RX start in the same cycle as an addr-2 write in IDLE SHALL lose to TX.
REQ-026 FIFO: read/write pointers of log2(FIFO_DEPTH) bits wrapping modulo depth; count of log2(FIFO_DEPTH)+1 bits.
REQ-027 FIFO: pop on I_READ & I_ADDR=1 when non-empty; pop when empty SHALL be ignored.
REQ-028 FIFO: simultaneous push and pop SHALL keep count unchanged, including when full.
REQ-029 Addr 0 read = {PERR, FERR, OVR, TXERR, busy(state!=IDLE), full, IRQEN, nonempty}.
REQ-030 Addr 0 write: bit1 loads IRQEN; bits 7..4 written 1 clear the matching flag (write-1-clear); clear SHALL win over a same-cycle set.
REQ-031 Addr 1 read = FIFO head (0x00 when empty); addr 2 read = last TX byte; addr 3 read = count zero-extended to 8 bits.

Reset
REQ-032 On I_RST=1 at a clock edge: state=IDLE, FIFO empty (pointers, count 0), all flags and IRQEN 0, O_IRQ=0, both PS2 lines Z, synchronizers =1, counters 0.
REQ-033 Reset mid-frame SHALL abort the frame immediately with no push and no flag set; reset dominates any same-cycle access.

Verification
REQ-034 Device sends 0x1C, parity 0, stop 1 -> count=1, addr1=0x1C; pop -> count=0, status bit0=0.
REQ-035 Write 0xED to addr 2 -> PS2CLK low 2000 cycles, data low 2000 cycles, bits 1,0,1,1,0,1,1,1 then parity 1 sent; device ack 0 -> IDLE, TXERR=0.
REQ-036 Send 9 valid bytes with FIFO_DEPTH=8, no pops -> full=1, OVR=1, FIFO holds first 8 in order; write 0x20 to addr 0 -> OVR=0.
REQ-037 Byte 0x55 with parity 0 -> PERR=1, count unchanged; with IRQEN=1 -> O_IRQ=1 one cycle after RXEND.
REQ-038 Device stops clocking after 4 bits -> after 50000 cycles state=IDLE, FERR=1, no push; next valid frame received normally.
REQ-039 Assert I_RST during TXBITS -> next cycle both lines Z, status=0x00, count=0.

Source files
------------

// File: rtl/ps2_fifo_ctrl.sv
// ps2_fifo_ctrl: PS/2 host port with an RX byte FIFO and a small register file.
//   Receives device-to-host frames into a FIFO and sends host-to-device bytes
//   (inhibit, request-to-send, bit shifting, ack check). Errors are sticky
//   write-1-clear flags and can raise an interrupt.
// Ports:
//   I_CLK       - system clock; everything runs on its rising edge
//   I_RST       - synchronous active-high reset
//   I_ADDR      - register select (0 status/ctrl, 1 RX FIFO, 2 TX byte, 3 count)
//   I_WRITE     - single-cycle write strobe
//   I_READ      - single-cycle read strobe (pops the FIFO at address 1)
//   I_WRDATA    - write data
//   O_RDDATA    - combinational read data for I_ADDR
//   O_IRQ       - registered interrupt
//   IO_PS2CLK   - open-drain PS/2 clock line
//   IO_PS2DATA  - open-drain PS/2 data line
module ps2_fifo_ctrl #(
  parameter int unsigned INHIBIT_CYC = 2000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic [1:0] I_ADDR,
  input  logic       I_WRITE,
  input  logic       I_READ,
  input  logic [7:0] I_WRDATA,
  output logic [7:0] O_RDDATA,
  output logic       O_IRQ,
  inout  wire        IO_PS2CLK,
  inout  wire        IO_PS2DATA
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_TXBITS,
    ST_TXACK,
    ST_RXBITS,
    ST_RXEND
  } state_t;

  state_t state;
  state_t state_d;

  // Line synchronizers and edge detect
  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic clk_fall;

  // Counters
  logic [INH_W-1:0] phase_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       bit_cnt;
  logic             tmo_hit;

  // Frame datapath
  logic [8:0] tx_shift;
  logic [9:0] rx_shift;
  logic [7:0] tx_byte;
  logic       clk_low;
  logic       dat_low;

  // FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;

  // Flags
  logic perr, ferr, ovr, txerr, irqen;

  // Decodes and FSM strobes
  logic wr_ctrl, wr_tx, rd_pop;
  logic tx_start, ack_err, tmo_err, rx_check;
  logic rx_good, push;
  logic set_perr, set_ferr, set_ovr, set_txerr;

  assign IO_PS2CLK  = clk_low ? 1'b0 : 1'bz;
  assign IO_PS2DATA = dat_low ? 1'b0 : 1'bz;

  // Two-stage synchronizers plus one history stage for fall detection
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= IO_PS2CLK;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= IO_PS2DATA;
      dat_s2 <= dat_s1;
    end
  end

  assign clk_fall = clk_s3 & ~clk_s2;

  assign wr_ctrl    = I_WRITE && (I_ADDR == 2'd0);
  assign wr_tx      = I_WRITE && (I_ADDR == 2'd2);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign rd_pop     = I_READ && (I_ADDR == 2'd1) && !fifo_empty;
  assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; a clock fall in the same cycle as the timeout wins
  always_comb begin
    state_d  = state;
    tx_start = 1'b0;
    ack_err  = 1'b0;
    tmo_err  = 1'b0;
    rx_check = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_tx) begin
          state_d  = ST_INHIBIT;
          tx_start = 1'b1;
        end else if (clk_fall && !dat_s2) begin
          state_d = ST_RXBITS;
        end
      end
      ST_INHIBIT: begin
        if (phase_cnt == INH_W'(INHIBIT_CYC - 1)) state_d = ST_START;
      end
      ST_START: begin
        if (phase_cnt == INH_W'(INHIBIT_CYC - 1)) state_d = ST_TXBITS;
      end
      ST_TXBITS: begin
        if (clk_fall) begin
          if (bit_cnt == 4'd9) state_d = ST_TXACK;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          tmo_err = 1'b1;
        end
      end
      ST_TXACK: begin
        if (clk_fall) begin
          state_d = ST_IDLE;
          ack_err = dat_s2;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          tmo_err = 1'b1;
        end
      end
      ST_RXBITS: begin
        if (clk_fall) begin
          if (bit_cnt == 4'd9) state_d = ST_RXEND;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          tmo_err = 1'b1;
        end
      end
      ST_RXEND: begin
        state_d  = ST_IDLE;
        rx_check = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame check: rx_shift = {stop, parity, data[7:0]}
  assign set_perr  = rx_check && !(^rx_shift[8:0]);
  assign set_ferr  = (rx_check && !rx_shift[9]) || tmo_err;
  assign rx_good   = rx_check && (^rx_shift[8:0]) && rx_shift[9];
  assign push      = rx_good && (!fifo_full || rd_pop);
  assign set_ovr   = rx_good && fifo_full && !rd_pop;
  assign set_txerr = (wr_tx && (state != ST_IDLE)) || ack_err;

  // Phase, bit and timeout counters; all restart on state entry
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      phase_cnt <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
    end else begin
      if (state_d != state) begin
        phase_cnt <= '0;
        bit_cnt   <= '0;
      end else begin
        if (state == ST_INHIBIT || state == ST_START) phase_cnt <= phase_cnt + INH_W'(1);
        if (clk_fall && bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
      end
      if (state_d != state || clk_fall) begin
        tmo_cnt <= '0;
      end else if (!tmo_hit) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

  // Shift registers and registered open-drain enables
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      tx_shift <= '0;
      rx_shift <= '0;
      tx_byte  <= '0;
      clk_low  <= 1'b0;
      dat_low  <= 1'b0;
    end else begin
      clk_low <= (state_d == ST_INHIBIT);
      if (tx_start) begin
        tx_byte  <= I_WRDATA;
        tx_shift <= {~^I_WRDATA, I_WRDATA};
      end else if (state == ST_TXBITS && clk_fall && bit_cnt != 4'd9) begin
        tx_shift <= {1'b0, tx_shift[8:1]};
      end
      if (state == ST_RXBITS && clk_fall) rx_shift <= {dat_s2, rx_shift[9:1]};
      // Start bit is held from START until the first device clock fall
      case (state_d)
        ST_START:  dat_low <= 1'b1;
        ST_TXBITS: if (state == ST_TXBITS && clk_fall) dat_low <= ~tx_shift[0];
        default:   dat_low <= 1'b0;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge I_CLK) begin
    if (push && !I_RST) mem[wr_ptr] <= rx_shift[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, rd_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags; a write-1-clear beats a set in the same cycle
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
      txerr <= 1'b0;
      irqen <= 1'b0;
      O_IRQ <= 1'b0;
    end else begin
      perr  <= (perr  | set_perr)  & ~(wr_ctrl & I_WRDATA[7]);
      ferr  <= (ferr  | set_ferr)  & ~(wr_ctrl & I_WRDATA[6]);
      ovr   <= (ovr   | set_ovr)   & ~(wr_ctrl & I_WRDATA[5]);
      txerr <= (txerr | set_txerr) & ~(wr_ctrl & I_WRDATA[4]);
      if (wr_ctrl) irqen <= I_WRDATA[1];
      O_IRQ <= irqen & (!fifo_empty | perr | ferr | ovr | txerr);
    end
  end

  // Register read mux
  always_comb begin
    O_RDDATA = '0;
    case (I_ADDR)
      2'd0:    O_RDDATA = {perr, ferr, ovr, txerr, (state != ST_IDLE), fifo_full, irqen, !fifo_empty};
      2'd1:    if (!fifo_empty) O_RDDATA = mem[rd_ptr];
      2'd2:    O_RDDATA = tx_byte;
      default: O_RDDATA = 8'(count);
    endcase
  end

endmodule

// File: tb/tb_ps2_fifo_ctrl.sv
`timescale 1ns/1ps
module tb_ps2_fifo_ctrl;

  localparam int unsigned INHIBIT_CYC = 2000;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned TIMEOUT_CYC = 50000;
  localparam int          FD          = 8;
  localparam int          H           = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] wrdata;
  logic [7:0] rddata;
  logic       irq;
  wire        ps2clk;
  wire        ps2data;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  pullup (ps2clk);
  pullup (ps2data);
  assign ps2clk  = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2data = dev_dat_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_fifo_ctrl #(
    .INHIBIT_CYC(INHIBIT_CYC),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .I_CLK     (clk),
    .I_RST     (rst),
    .I_ADDR    (addr),
    .I_WRITE   (wr),
    .I_READ    (rd),
    .I_WRDATA  (wrdata),
    .O_RDDATA  (rddata),
    .O_IRQ     (irq),
    .IO_PS2CLK (ps2clk),
    .IO_PS2DATA(ps2data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue, flags as plain bits
  logic [7:0] q[$];
  bit m_perr, m_ferr, m_ovr, m_txerr, m_irqen;

  function automatic logic [7:0] exp_status();
    return {m_perr, m_ferr, m_ovr, m_txerr, 1'b0, 1'(q.size() == FD), m_irqen, 1'(q.size() != 0)};
  endfunction

  function automatic logic exp_irq();
    return m_irqen & ((q.size() != 0) | m_perr | m_ferr | m_ovr | m_txerr);
  endfunction

  function automatic logic [7:0] exp_head();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  function automatic logic odd_par(input logic [7:0] b);
    return 1'(($countones(b) % 2) == 0);
  endfunction

  task automatic model_reset();
    q.delete();
    m_perr = 0; m_ferr = 0; m_ovr = 0; m_txerr = 0; m_irqen = 0;
  endtask

  task automatic model_rx(input logic [7:0] b, input bit pbad, input bit sbad);
    if (pbad) m_perr = 1;
    if (sbad) m_ferr = 1;
    if (!pbad && !sbad) begin
      if (q.size() < FD) q.push_back(b);
      else m_ovr = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = rddata;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    addr = a; wrdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic pop_fifo();
    addr = 2'd1; rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Device-to-host frame: start, 8 data LSB first, parity, stop
  task automatic dev_send_frame(input logic [7:0] b, input bit pbad, input bit sbad);
    logic [10:0] f;
    f = {~sbad, odd_par(b) ^ pbad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      dev_dat_low = ~f[i];
      repeat (H) tick();
      dev_clk_low = 1'b1;
      repeat (H) tick();
      dev_clk_low = 1'b0;
    end
    repeat (H) tick();
    dev_dat_low = 1'b0;
    repeat (H) tick();
  endtask

  // Device side of a host-to-device frame: 10 sampled bits then the ack pulse
  task automatic dev_recv_tx(input bit ack_bad, output logic [9:0] bits);
    bits = '0;
    repeat (H) tick();
    for (int k = 0; k < 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) tick();
      bits[k] = ps2data;
      dev_clk_low = 1'b0;
      repeat (H) tick();
    end
    dev_dat_low = ~ack_bad;
    repeat (H) tick();
    dev_clk_low = 1'b1;
    repeat (H) tick();
    dev_clk_low = 1'b0;
    repeat (H) tick();
    dev_dat_low = 1'b0;
    repeat (H) tick();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b1; addr = 2'd2; wrdata = 8'hA5; wr = 1'b1;
    tick();
    tick();
    wr = 1'b0; rst = 1'b0;
    model_reset();
    reg_read(2'd0, got); checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", got); end
    reg_read(2'd3, got); checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL reset_count got=%h exp=00", got); end
    reg_read(2'd2, got); checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL reset_txbyte got=%h exp=00", got); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++;
    if (ps2clk !== 1'b1 || ps2data !== 1'b1) begin
      errors++; $display("FAIL reset_lines got=%b%b exp=11", ps2clk, ps2data);
    end
  endtask

  task automatic test_rx_basic();
    logic [7:0] got;
    dev_send_frame(8'h1C, 0, 0);
    model_rx(8'h1C, 0, 0);
    reg_read(2'd3, got); checks++;
    if (got !== 8'(q.size())) begin errors++; $display("FAIL rx1c_count got=%h exp=%h", got, 8'(q.size())); end
    reg_read(2'd1, got); checks++;
    if (got !== 8'h1C) begin errors++; $display("FAIL rx1c_head got=%h exp=1c", got); end
    pop_fifo();
    void'(q.pop_front());
    reg_read(2'd3, got); checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL rx1c_pop_count got=%h exp=00", got); end
    reg_read(2'd0, got); checks++;
    if (got[0] !== 1'b0) begin errors++; $display("FAIL rx1c_nonempty got=%b exp=0", got[0]); end
    pop_fifo();
    reg_read(2'd3, got); checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL empty_pop_count got=%h exp=00", got); end
    reg_read(2'd1, got); checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL empty_head got=%h exp=00", got); end
  endtask

  task automatic test_rx_random(input int n);
    logic [7:0] got, b, wv;
    bit pbad, sbad;
    for (int i = 0; i < n; i++) begin
      b    = 8'($urandom);
      pbad = ($urandom_range(0, 5) == 0);
      sbad = ($urandom_range(0, 7) == 0);
      dev_send_frame(b, pbad, sbad);
      model_rx(b, pbad, sbad);
      reg_read(2'd3, got); checks++;
      if (got !== 8'(q.size())) begin errors++; $display("FAIL rnd_count[%0d] got=%h exp=%h", i, got, 8'(q.size())); end
      reg_read(2'd0, got); checks++;
      if (got !== exp_status()) begin errors++; $display("FAIL rnd_status[%0d] got=%h exp=%h", i, got, exp_status()); end
      if ($urandom_range(0, 2) == 0) begin
        reg_read(2'd1, got); checks++;
        if (got !== exp_head()) begin errors++; $display("FAIL rnd_head[%0d] got=%h exp=%h", i, got, exp_head()); end
        pop_fifo();
        if (q.size() != 0) void'(q.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        wv = 8'($urandom);
        reg_write(2'd0, wv);
        if (wv[7]) m_perr = 0;
        if (wv[6]) m_ferr = 0;
        if (wv[5]) m_ovr = 0;
        if (wv[4]) m_txerr = 0;
        m_irqen = wv[1];
        tick();
        tick();
        checks++;
        if (irq !== exp_irq()) begin errors++; $display("FAIL rnd_irq[%0d] got=%b exp=%b", i, irq, exp_irq()); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got, b;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      dev_send_frame(b, 0, 0);
      model_rx(b, 0, 0);
    end
    reg_read(2'd0, got); checks++;
    if (got !== exp_status() || got[2] !== 1'b1 || got[5] !== 1'b1) begin
      errors++; $display("FAIL ovf_status got=%h exp=%h", got, exp_status());
    end
    reg_read(2'd3, got); checks++;
    if (got !== 8'(FD)) begin errors++; $display("FAIL ovf_count got=%h exp=%h", got, 8'(FD)); end
    for (int i = 0; i < FD; i++) begin
      reg_read(2'd1, got); checks++;
      if (got !== exp_head()) begin errors++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, got, exp_head()); end
      pop_fifo();
      void'(q.pop_front());
    end
    reg_write(2'd0, 8'h20);
    m_ovr = 0;
    reg_read(2'd0, got); checks++;
    if (got !== exp_status()) begin errors++; $display("FAIL ovf_clear got=%h exp=%h", got, exp_status()); end
  endtask

  task automatic test_parity_irq();
    logic [7:0] got;
    do_reset();
    reg_write(2'd0, 8'h02);
    m_irqen = 1;
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL perr_irq_idle got=%b exp=0", irq); end
    dev_send_frame(8'h55, 1, 0);
    model_rx(8'h55, 1, 0);
    reg_read(2'd0, got); checks++;
    if (got !== exp_status()) begin errors++; $display("FAIL perr_status got=%h exp=%h", got, exp_status()); end
    reg_read(2'd3, got); checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL perr_count got=%h exp=00", got); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL perr_irq got=%b exp=1", irq); end
    reg_write(2'd0, 8'h82);
    m_perr = 0;
    tick();
    tick();
    checks++;
    if (irq !== exp_irq()) begin errors++; $display("FAIL perr_irq_clear got=%b exp=%b", irq, exp_irq()); end
  endtask

  // One host-to-device byte; optionally a second write while busy
  task automatic run_tx(input logic [7:0] b, input bit ack_bad, input bit extra_wr);
    logic [7:0] got;
    logic [9:0] bits;
    int lowc;
    lowc = 0;
    reg_write(2'd2, b);
    if (ps2clk === 1'b0) lowc++;
    if (extra_wr) begin
      reg_write(2'd2, 8'h11);
      m_txerr = 1;
      if (ps2clk === 1'b0) lowc++;
    end
    for (int i = 0; i < 3000 && ps2clk === 1'b0; i++) begin
      tick();
      if (ps2clk === 1'b0) lowc++;
    end
    checks++;
    if (lowc != int'(INHIBIT_CYC)) begin errors++; $display("FAIL tx_inhibit_len got=%0d exp=%0d", lowc, INHIBIT_CYC); end
    checks++;
    if (ps2data !== 1'b0) begin errors++; $display("FAIL tx_start_low got=%b exp=0", ps2data); end
    repeat (INHIBIT_CYC - 20) tick();
    reg_read(2'd0, got); checks++;
    if (ps2data !== 1'b0 || got[3] !== 1'b1) begin
      errors++; $display("FAIL tx_start_hold data=%b busy=%b exp=0,1", ps2data, got[3]);
    end
    repeat (30) tick();
    dev_recv_tx(ack_bad, bits);
    if (ack_bad) m_txerr = 1;
    checks++;
    if (bits[7:0] !== b) begin errors++; $display("FAIL tx_data got=%h exp=%h", bits[7:0], b); end
    checks++;
    if (bits[8] !== odd_par(b)) begin errors++; $display("FAIL tx_parity got=%b exp=%b", bits[8], odd_par(b)); end
    checks++;
    if (bits[9] !== 1'b1) begin errors++; $display("FAIL tx_stop got=%b exp=1", bits[9]); end
    reg_read(2'd0, got); checks++;
    if (got !== exp_status()) begin errors++; $display("FAIL tx_status got=%h exp=%h", got, exp_status()); end
    reg_read(2'd2, got); checks++;
    if (got !== b) begin errors++; $display("FAIL tx_byte got=%h exp=%h", got, b); end
  endtask

  task automatic test_tx();
    logic [7:0] got;
    do_reset();
    run_tx(8'hED, 0, 1);
    reg_write(2'd0, 8'h10);
    m_txerr = 0;
    reg_read(2'd0, got); checks++;
    if (got !== exp_status()) begin errors++; $display("FAIL txerr_clear got=%h exp=%h", got, exp_status()); end
    run_tx(8'($urandom), 1, 0);
  endtask

  task automatic test_timeout();
    logic [7:0] got, b;
    logic [4:0] f;
    bit idle_seen;
    do_reset();
    f = {4'($urandom), 1'b0};
    for (int i = 0; i < 5; i++) begin
      dev_dat_low = ~f[i];
      repeat (H) tick();
      dev_clk_low = 1'b1;
      repeat (H) tick();
      dev_clk_low = 1'b0;
    end
    dev_dat_low = 1'b0;
    repeat (TIMEOUT_CYC - 100) tick();
    reg_read(2'd0, got); checks++;
    if (got[3] !== 1'b1) begin errors++; $display("FAIL tmo_early busy=%b exp=1", got[3]); end
    idle_seen = 0;
    for (int i = 0; i < 300 && !idle_seen; i++) begin
      tick();
      reg_read(2'd0, got);
      if (got[3] === 1'b0) idle_seen = 1;
    end
    checks++;
    if (!idle_seen) begin errors++; $display("FAIL tmo_idle busy=%b exp=0", got[3]); end
    m_ferr = 1;
    reg_read(2'd0, got); checks++;
    if (got !== exp_status()) begin errors++; $display("FAIL tmo_status got=%h exp=%h", got, exp_status()); end
    b = 8'($urandom);
    dev_send_frame(b, 0, 0);
    model_rx(b, 0, 0);
    reg_read(2'd3, got); checks++;
    if (got !== 8'h01) begin errors++; $display("FAIL tmo_next_count got=%h exp=01", got); end
    reg_read(2'd1, got); checks++;
    if (got !== b) begin errors++; $display("FAIL tmo_next_head got=%h exp=%h", got, b); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] got;
    do_reset();
    dev_send_frame(8'h3A, 0, 0);
    model_rx(8'h3A, 0, 0);
    reg_read(2'd3, got); checks++;
    if (got !== 8'h01) begin errors++; $display("FAIL rstmid_pre_count got=%h exp=01", got); end
    reg_write(2'd2, 8'h00);
    repeat (2 * INHIBIT_CYC + 20) tick();
    for (int k = 0; k < 3; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) tick();
      dev_clk_low = 1'b0;
      repeat (H) tick();
    end
    reg_read(2'd0, got); checks++;
    if (ps2data !== 1'b0 || got[3] !== 1'b1) begin
      errors++; $display("FAIL rstmid_txbits data=%b busy=%b exp=0,1", ps2data, got[3]);
    end
    rst = 1'b1; addr = 2'd1; rd = 1'b1;
    tick();
    rd = 1'b0;
    model_reset();
    checks++;
    if (ps2clk !== 1'b1 || ps2data !== 1'b1) begin
      errors++; $display("FAIL rstmid_lines got=%b%b exp=11", ps2clk, ps2data);
    end
    reg_read(2'd0, got); checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL rstmid_status got=%h exp=00", got); end
    reg_read(2'd3, got); checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL rstmid_count got=%h exp=00", got); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; addr = 2'd0; wr = 1'b0; rd = 1'b0; wrdata = 8'h00;
    model_reset();
    test_reset();
    test_rx_basic();
    test_rx_random(24);
    test_overflow();
    test_parity_irq();
    test_tx();
    test_timeout();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
